inst_rom_resp: RTL and testbench

INST_ROM_RESP -- requirements
Module: inst_rom_resp

---
 rtl/inst_rom_resp_pkg.sv | 15 +
 rtl/inst_mem_array.sv | 33 +++
 rtl/inst_rom_resp.sv | 121 ++++++++++++
 tb/tb_inst_rom_resp.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_rom_resp_pkg.sv
// Shared fetch-side types and widths.
// Imported by the instruction ROM and its storage array.
package inst_rom_resp_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_mem_array.sv
// Instruction storage: one write port, one registered read port.
// A same-edge write and read returns the old word.
import inst_rom_resp_pkg::*;

module inst_mem_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [INST_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [INST_W-1:0]     rd_data
);

  logic [INST_W-1:0] mem [2**DEPTH_LOG2];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/inst_rom_resp.sv
// Wait-stated instruction fetch responder.
// Stalls the PC stage, then strobes one word per fetch.
import inst_rom_resp_pkg::*;

module inst_rom_resp #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_ce,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic                  i_wr_en,
  input  logic [DEPTH_LOG2-1:0] i_wr_addr,
  input  logic [INST_W-1:0]     i_wr_data,
  output logic [INST_W-1:0]     o_inst,
  output logic                  o_valid,
  output logic                  o_stall,
  output logic                  o_addr_err
);

  localparam int CNT_INIT =
    (WAIT_STATES > 1) ? WAIT_STATES - 2 : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(CNT_INIT);

  fetch_state_e          state;
  fetch_state_e          state_next;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic [DEPTH_LOG2+1:0] addr_q;
  logic                  capture;
  logic                  stall;
  logic                  rd_en;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [INST_W-1:0]     rd_data;
  logic                  valid;
  logic                  misaligned;
  logic                  unused_bits;

  assign unused_bits = ^i_addr[ADDR_W-1:DEPTH_LOG2+2];

  // Next state, stall and read issue.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    stall      = 1'b0;
    rd_en      = 1'b0;
    rd_idx     = i_addr[DEPTH_LOG2+1:2];
    unique case (state)
      IDLE, RESP: begin
        if (i_ce) begin
          capture = 1'b1;
          stall   = (WAIT_STATES > 0);
          if (WAIT_STATES > 1) begin
            state_next = WAIT;
            cnt_next   = CNT_LOAD;
          end else begin
            state_next = RESP;
            rd_en      = 1'b1;
          end
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        stall  = 1'b1;
        rd_idx = addr_q[DEPTH_LOG2+1:2];
        if (cnt == '0) begin
          state_next = RESP;
          rd_en      = 1'b1;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!rst) begin
      capture = 1'b0;
      stall   = 1'b0;
      rd_en   = 1'b0;
    end
  end

  // State, wait counter and captured address.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture) begin
        addr_q <= i_addr[DEPTH_LOG2+1:0];
      end
    end
  end

  inst_mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk    (clk),
    .wr_en  (i_wr_en & rst),
    .wr_addr(i_wr_addr),
    .wr_data(i_wr_data),
    .rd_en  (rd_en),
    .rd_addr(rd_idx),
    .rd_data(rd_data)
  );

  assign valid      = rst && (state == RESP);
  assign misaligned = (addr_q[1:0] != 2'b00);

  assign o_valid    = valid;
  assign o_addr_err = valid && misaligned;
  assign o_inst     = (valid && !misaligned) ? rd_data : '0;
  assign o_stall    = stall;

endmodule

// File: tb/tb_inst_rom_resp.sv
// Bench: two responders (2 and 0 wait states) on shared inputs.
// Outputs are compared each cycle against a countdown reference.
module tb_inst_rom_resp;

  localparam int DL    = 10;
  localparam int DEPTH = 1 << DL;
  localparam int WS_A  = 2;
  localparam int WS_B  = 0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ce = 1'b0;
  logic [31:0]   addr = '0;
  logic          wr_en = 1'b0;
  logic [DL-1:0] wr_addr = '0;
  logic [31:0]   wr_data = '0;

  logic [31:0] inst_a, inst_b;
  logic        valid_a, valid_b;
  logic        stall_a, stall_b;
  logic        err_a, err_b;

  always #5 clk = ~clk;

  inst_rom_resp #(
    .DEPTH_LOG2(DL), .WAIT_STATES(WS_A)
  ) u_ws2 (
    .clk(clk), .rst(rst), .i_ce(ce), .i_addr(addr),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .o_inst(inst_a),
    .o_valid(valid_a), .o_stall(stall_a),
    .o_addr_err(err_a)
  );

  inst_rom_resp #(
    .DEPTH_LOG2(DL), .WAIT_STATES(WS_B)
  ) u_ws0 (
    .clk(clk), .rst(rst), .i_ce(ce), .i_addr(addr),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .o_inst(inst_b),
    .o_valid(valid_b), .o_stall(stall_b),
    .o_addr_err(err_b)
  );

  int checks = 0;
  int failures = 0;

  // Reference: memory image plus, per DUT, cycles left until
  // its response strobe (-1 = nothing in flight).
  logic [31:0] mem [DEPTH];
  int          rem [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_data [2];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic c,
                      input logic [31:0] a, input logic w,
                      input logic [DL-1:0] wa,
                      input logic [31:0] wd);
    int          ws;
    logic        v, e, s;
    logic        gv, gs, ge;
    logic [31:0] gi;
    logic [31:0] ei;
    @(negedge clk);
    rst = r; ce = c; addr = a;
    wr_en = w; wr_addr = wa; wr_data = wd;
    #1;
    for (int k = 0; k < 2; k++) begin
      ws = (k == 0) ? WS_A : WS_B;
      gv = (k == 0) ? valid_a : valid_b;
      gs = (k == 0) ? stall_a : stall_b;
      ge = (k == 0) ? err_a : err_b;
      gi = (k == 0) ? inst_a : inst_b;
      v = r && (rem[k] == 0);
      e = v && (p_addr[k][1:0] != 2'b00);
      s = r && ((rem[k] > 0) || (c && ws > 0));
      ei = (v && !e) ? p_data[k] : 32'h0;
      chk($sformatf("valid_ws%0d", ws), 32'(gv), 32'(v));
      chk($sformatf("stall_ws%0d", ws), 32'(gs), 32'(s));
      chk($sformatf("err_ws%0d", ws), 32'(ge), 32'(e));
      if (v || !r) begin
        chk($sformatf("inst_ws%0d", ws), gi, ei);
      end
    end
    for (int k = 0; k < 2; k++) begin
      ws = (k == 0) ? WS_A : WS_B;
      if (!r) begin
        rem[k] = -1;
      end else if (rem[k] > 0) begin
        rem[k] = rem[k] - 1;
      end else if (c) begin
        rem[k] = (ws > 1) ? ws - 1 : 0;
        p_addr[k] = a;
      end else begin
        rem[k] = -1;
      end
      if (rem[k] == 0) begin
        p_data[k] = mem[p_addr[k][DL+1:2]];
      end
    end
    if (r && w) begin
      mem[wa] = wd;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, '0, 32'h0);
    end
  endtask

  task automatic fetch(input logic [31:0] a);
    step(1'b1, 1'b1, a, 1'b0, '0, 32'h0);
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    step(1'b1, 1'b0, 32'h0, 1'b1, DL'(idx), d);
  endtask

  initial begin
    logic          r, c, w;
    logic [31:0]   a, wd;
    logic [DL-1:0] wa;
    rem[0] = -1;
    rem[1] = -1;
    p_addr[0] = '0;
    p_addr[1] = '0;
    p_data[0] = '0;
    p_data[1] = '0;

    // reset with a fetch request pending
    step(1'b0, 1'b1, 32'h4, 1'b0, '0, 32'h0);
    step(1'b0, 1'b1, 32'h4, 1'b0, '0, 32'h0);

    for (int i = 0; i < DEPTH; i++) begin
      load(i, 32'h3000_0000 | 32'(i));
    end
    load(1, 32'h2402_0005);
    load(2, 32'h1111_1111);
    idle(1);

    // single aligned fetch, then back-to-back
    fetch(32'h4);
    idle(4);
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h8);
    idle(4);

    // misaligned, and index wrap
    fetch(32'h6);
    idle(4);
    fetch(32'h1004);
    idle(4);

    // reset mid-fetch, with a suppressed write
    fetch(32'h4);
    step(1'b0, 1'b0, 32'h0, 1'b1, 10'd5, 32'hdead_beef);
    idle(5);
    fetch(32'h14);
    idle(4);

    // write colliding with the read edge
    step(1'b1, 1'b1, 32'h8, 1'b1, 10'd2, 32'haaaa_aaaa);
    idle(4);
    fetch(32'h8);
    step(1'b1, 1'b0, 32'h0, 1'b1, 10'd2, 32'hbbbb_bbbb);
    idle(4);
    fetch(32'h8);
    idle(4);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 39) != 0);
      c = 1'($urandom_range(0, 1));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      w = ($urandom_range(0, 3) == 0);
      wa = DL'($urandom);
      wd = $urandom;
      step(r, c, a, w, wa, wd);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
